sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller for the on-die analog front end of the analog tile. It drives the track/hold switch and the capacitive DAC code toward the analog macro and reads back the comparator decision, producing one WIDTH-bit conversion per `start` request. It is the digital end of the comparator/DAC interface exposed on the analog pins, and sits between the tile's digital I/O logic and the analog macro.

---
 rtl/sar_pkg.sv | 27 ++
 rtl/sar_cmp_sync.sv | 25 ++
 rtl/sar_adc_ctrl.sv | 137 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
// SAR_CMP_SYNC_EN selects the synchronized-comparator build (4-cycle bit period).
package sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRIAL,
        ST_WAIT1,
        ST_WAIT2,
        ST_DECIDE,
        ST_DONE
    } sar_state_e;

`ifdef SAR_CMP_SYNC_EN
    localparam int unsigned SAR_BIT_CYCLES = 4;
`else
    localparam int unsigned SAR_BIT_CYCLES = 2;
`endif

    localparam int unsigned SAR_WIDTH_MIN  = 4;
    localparam int unsigned SAR_WIDTH_MAX  = 12;
    localparam int unsigned SAR_SAMPLE_MIN = 1;
    localparam int unsigned SAR_SAMPLE_MAX = 255;
    localparam int unsigned SAR_CNT_W      = 8;

endpackage

// File: rtl/sar_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator decision.
// Instantiated by sar_adc_ctrl only when SAR_CMP_SYNC_EN is defined.
module sar_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track/hold, MSB-first DAC trials, result capture.
// SAR_CMP_SYNC_EN: comparator through a 2-flop synchronizer, bit period TRIAL/WAIT1/WAIT2/DECIDE.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);

    if (WIDTH < SAR_WIDTH_MIN || WIDTH > SAR_WIDTH_MAX) begin : g_bad_width
        $error("sar_adc_ctrl: WIDTH out of range");
    end
    if (SAMPLE_CYCLES < SAR_SAMPLE_MIN || SAMPLE_CYCLES > SAR_SAMPLE_MAX) begin : g_bad_sample
        $error("sar_adc_ctrl: SAMPLE_CYCLES out of range");
    end

    sar_state_e             r_state;
    logic [SAR_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]       r_work;
    logic [WIDTH-1:0]       r_mask;
    logic [WIDTH-1:0]       r_dac;
    logic [WIDTH-1:0]       r_result;
    logic                   r_sample_en;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_cmp;
    logic [WIDTH-1:0]       w_decided;
    logic [WIDTH-1:0]       w_next_trial;

`ifdef SAR_CMP_SYNC_EN
    sar_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (cmp_in),
        .o_q   (w_cmp)
    );
`else
    assign w_cmp = cmp_in;
`endif

    // r_work holds the current trial code; r_mask is the one-hot bit under test
    always_comb begin
        w_decided    = w_cmp ? r_work : (r_work & ~r_mask);
        w_next_trial = w_decided | (r_mask >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_mask      <= '0;
            r_dac       <= '0;
            r_result    <= '0;
            r_sample_en <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (abort && r_state != ST_IDLE) begin
                r_state     <= ST_IDLE;
                r_dac       <= '0;
                r_sample_en <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state     <= ST_SAMPLE;
                            r_cnt       <= SAR_CNT_W'(SAMPLE_CYCLES - 1);
                            r_sample_en <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (r_cnt == '0) begin
                            r_state     <= ST_TRIAL;
                            r_sample_en <= 1'b0;
                            r_work      <= {1'b1, {(WIDTH-1){1'b0}}};
                            r_mask      <= {1'b1, {(WIDTH-1){1'b0}}};
                            r_dac       <= {1'b1, {(WIDTH-1){1'b0}}};
                        end else begin
                            r_cnt <= r_cnt - SAR_CNT_W'(1);
                        end
                    end
                    ST_TRIAL:  r_state <= (SAR_BIT_CYCLES == 4) ? ST_WAIT1 : ST_DECIDE;
                    ST_WAIT1:  r_state <= ST_WAIT2;
                    ST_WAIT2:  r_state <= ST_DECIDE;
                    ST_DECIDE: begin
                        if (r_mask[0]) begin
                            r_state  <= ST_DONE;
                            r_result <= w_decided;
                            r_valid  <= 1'b1;
                            r_dac    <= '0;
                            r_work   <= '0;
                            r_mask   <= '0;
                        end else begin
                            r_state <= ST_TRIAL;
                            r_work  <= w_next_trial;
                            r_dac   <= w_next_trial;
                            r_mask  <= r_mask >> 1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_dac       <= '0;
                        r_sample_en <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_en = r_sample_en;
    assign dac_code  = r_dac;
    assign result    = r_result;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: directed conversions, abort, reset, re-issued start.
// Expected valid edge follows the SAR_CMP_SYNC_EN build selection.
module tb_sar_adc_ctrl;

    localparam int W  = 8;
    localparam int SC = 4;
`ifdef SAR_CMP_SYNC_EN
    localparam int BITC = 4;
`else
    localparam int BITC = 2;
`endif
    localparam int LAT = SC + BITC * W + 1;

    typedef struct {
        logic [7:0] res;
        int         at_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp_in;
    logic         sample_en;
    logic [W-1:0] dac_code;
    logic [W-1:0] result;
    logic         valid;
    logic         busy;

    logic [7:0]   vin = 8'h00;
    int           mode = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           chk_trials = 1'b0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_dac = '0;

    exp_t         sb_q[$];
    logic [7:0]   trial_q[$];

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cmp_in    (cmp_in),
        .sample_en (sample_en),
        .dac_code  (dac_code),
        .result    (result),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // comparator model: mode 0 compares against vin, 1 stuck high, 2 stuck low
    assign cmp_in = (mode == 0) ? (vin >= dac_code) : (mode == 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("valid_one_cycle", 32'(prev_valid), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("valid_edge", 32'(cyc + 1), 32'(e.at_edge));
            end
        end
        if (chk_trials && dac_code != prev_dac && dac_code != '0) begin
            if (trial_q.size() == 0) check("extra_trial", 32'(dac_code), 32'd0);
            else check("dac_trial", 32'(dac_code), 32'(trial_q.pop_front()));
        end
        prev_valid <= valid;
        prev_dac   <= dac_code;
    end

    task automatic convert(input logic [7:0] v, input int m, input logic [7:0] exp_res,
                           input bit reissue);
        int  e0;
        bit  done;
        vin  = v;
        mode = m;
        e0   = cyc + 1;
        sb_q.push_back('{exp_res, e0 + LAT});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (reissue) start = (cyc + 1 == e0 + 5) || (cyc + 1 == e0 + 15);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("busy_fall_edge", 32'(cyc), 32'(e0 + LAT));
    endtask

    initial begin
        int e0;
        #1;
        check("rst_sample_en", 32'(sample_en), 32'd0);
        check("rst_dac", 32'(dac_code), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        convert(8'h00, 1, 8'hFF, 1'b0);
        convert(8'h00, 2, 8'h00, 1'b0);
        convert(8'h42, 0, 8'h42, 1'b1);

        trial_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        chk_trials = 1'b1;
        convert(8'hA5, 0, 8'hA5, 1'b0);
        chk_trials = 1'b0;
        check("trials_consumed", 32'(trial_q.size()), 32'd0);

        // abort sampled at edge 10 of a conversion
        vin = 8'h11; mode = 0;
        e0 = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && (cyc + 1 < e0 + 10); i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sample_en", 32'(sample_en), 32'd0);
        check("abort_dac", 32'(dac_code), 32'd0);
        check("abort_result_kept", 32'(result), 32'hA5);
        repeat (30) @(negedge clk);
        check("abort_still_idle", 32'(busy), 32'd0);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle_busy", 32'(busy), 32'd0);
        check("abort_start_idle_sample", 32'(sample_en), 32'd0);
        @(negedge clk);
        check("abort_start_idle_busy2", 32'(busy), 32'd0);

        // reset asserted during the first TRIAL
        vin = 8'h77; mode = 0;
        e0 = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && (cyc < e0 + SC); i++) @(negedge clk);
        check("trial_dac_before_rst", 32'(dac_code), 32'h80);
        rst_n = 1'b0;
        #1;
        check("async_rst_dac", 32'(dac_code), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_sample_en", 32'(sample_en), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        convert(8'h3C, 0, 8'h3C, 1'b0);
        convert(8'h5A, 0, 8'h5A, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
